char_anim_sequencer: RTL and testbench

Parametrised sprite-frame sequencer between the character physics FSM and the sprite ROM / pixel pipeline. Samples `char_state`, `vel_x` and `vel_y` on every `character_clk` tick and produces a registered sprite frame index and a horizontal mirror flag. Adds features beyond single-pose selection:
- multi-frame walk cycles
- idle breathing
- hard/soft landing holds with abort
- collision pose
- latched facing direction

---
 rtl/char_anim_pkg.sv | 38 +++
 rtl/char_anim_tick_counter.sv | 30 +++
 rtl/char_anim_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_char_anim_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/char_anim_pkg.sv
// Shared definitions for the character sprite-frame sequencer: physics state
// codes, sprite frame indices and width helpers.
package char_anim_pkg;

    // Physics FSM state codes as presented on char_state
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEFT      = 3'd1,
        ST_RIGHT     = 3'd2,
        ST_CHARGE    = 3'd3,
        ST_JUMP      = 3'd4,
        ST_COLLISION = 3'd5,
        ST_FALL      = 3'd6,
        ST_HOLD      = 3'd7
    } char_state_e;

    // Sprite ROM frame indices; walk frames follow from WALK_BASE upwards
    localparam int unsigned FR_IDLE_A    = 0;
    localparam int unsigned FR_IDLE_B    = 1;
    localparam int unsigned FR_CHARGE    = 2;
    localparam int unsigned FR_JUMP_UP   = 3;
    localparam int unsigned FR_JUMP_DOWN = 4;
    localparam int unsigned FR_HARD_LAND = 5;
    localparam int unsigned FR_SOFT_LAND = 6;
    localparam int unsigned FR_BONK      = 7;
    localparam int unsigned WALK_BASE    = 8;

    // Width of the frame index for a given walk-cycle length
    function automatic int unsigned frame_w(input int unsigned walk_frames);
        return $clog2(8 + walk_frames);
    endfunction

    // Counter width for a mod-N counter, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/char_anim_tick_counter.sv
// Tick-enabled mod-MAX up counter.
// Ports: clk, rst_n (async active-low), tick (count enable), restart
// (synchronous clear, wins over tick), count (current value), wrap_c (count
// sits at MAX-1, so the next enabled tick wraps it to 0).
module char_anim_tick_counter #(
    parameter int unsigned MAX   = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             restart,
    output logic [WIDTH-1:0] count,
    output logic             wrap_c
);

    // Terminal-count flag; independent of tick so callers can gate it freely
    assign wrap_c = (count == WIDTH'(MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (tick) begin
            count <= wrap_c ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/char_anim_sequencer.sv
// Sprite-frame sequencer between the character physics FSM and the sprite
// pipeline. Registers the physics inputs once, then on each delayed tick
// selects the next sprite frame by a fixed priority and latches facing.
// Ports: sys_clk, sys_rst_n (async active-low), character_clk (update tick),
// char_state, vel_x, vel_y (signed, +up) in; frame_id, mirror (1 = facing
// left), land_busy (landing hold in progress) out, all registered.
module char_anim_sequencer
    import char_anim_pkg::*;
#(
    parameter int unsigned SIGNED_PHY_WIDTH = 17,
    parameter int unsigned REFRESH_RATE     = 64,
    parameter int unsigned WALK_FRAMES      = 4,
    parameter int unsigned WALK_DIV         = 8,
    parameter int unsigned LAND_HOLD_TICKS  = 64,
    parameter int          MAX_VEL_Y        = 10,
    parameter int unsigned HARD_LAND_SHIFT  = 2,
    parameter int unsigned FRAME_ID_WIDTH   = frame_w(WALK_FRAMES)
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic                               character_clk,
    input  logic [2:0]                         char_state,
    input  logic signed [SIGNED_PHY_WIDTH-1:0] vel_x,
    input  logic signed [SIGNED_PHY_WIDTH-1:0] vel_y,
    output logic [FRAME_ID_WIDTH-1:0]          frame_id,
    output logic                               mirror,
    output logic                               land_busy
);

    localparam int unsigned PW = SIGNED_PHY_WIDTH;
    localparam int unsigned FW = FRAME_ID_WIDTH;
    localparam int unsigned BW = cnt_w(REFRESH_RATE);
    localparam int unsigned DW = cnt_w(WALK_DIV);
    localparam int unsigned HW = cnt_w(LAND_HOLD_TICKS);
    localparam int          HARD_THRESH = -(MAX_VEL_Y >>> HARD_LAND_SHIFT);

    localparam logic [FW-1:0] F_IDLE_A    = FW'(FR_IDLE_A);
    localparam logic [FW-1:0] F_IDLE_B    = FW'(FR_IDLE_B);
    localparam logic [FW-1:0] F_CHARGE    = FW'(FR_CHARGE);
    localparam logic [FW-1:0] F_JUMP_UP   = FW'(FR_JUMP_UP);
    localparam logic [FW-1:0] F_JUMP_DOWN = FW'(FR_JUMP_DOWN);
    localparam logic [FW-1:0] F_HARD_LAND = FW'(FR_HARD_LAND);
    localparam logic [FW-1:0] F_SOFT_LAND = FW'(FR_SOFT_LAND);
    localparam logic [FW-1:0] F_BONK      = FW'(FR_BONK);
    localparam logic [FW-1:0] F_WALK_BASE = FW'(WALK_BASE);
    localparam logic [FW-1:0] F_WALK_LAST = FW'(WALK_BASE + WALK_FRAMES - 1);
    localparam logic [BW-1:0] BREATHE_HALF = BW'(REFRESH_RATE / 2);

    logic                 tick_d;
    char_state_e          state_d;
    logic signed [PW-1:0] vel_x_d;
    logic signed [PW-1:0] vel_y_d;
    logic signed [PW-1:0] vel_y_prev;

    logic [FW-1:0] frame_nxt;
    logic          mirror_nxt;
    logic          busy_nxt;

    logic          br_tick, br_restart, br_wrap_c;
    logic          wd_tick, wd_restart, wd_wrap_c;
    logic          hd_tick, hd_restart, hd_wrap_c;
    logic [BW-1:0] br_count;
    logic [DW-1:0] wd_count;
    logic [HW-1:0] hd_count;

    logic is_walk, is_idle, is_jump;
    logic vy_nz, vy_neg, vx_nz, vx_neg;

    assign is_walk = (frame_id >= F_WALK_BASE);
    assign is_idle = (frame_id == F_IDLE_A) || (frame_id == F_IDLE_B);
    assign is_jump = (frame_id == F_JUMP_UP) || (frame_id == F_JUMP_DOWN);
    assign vy_nz   = |vel_y_d;
    assign vy_neg  = vel_y_d[PW-1];
    assign vx_nz   = |vel_x_d;
    assign vx_neg  = vel_x_d[PW-1];

    // Breathing phase, walk-frame divider, landing hold
    char_anim_tick_counter #(.MAX(REFRESH_RATE), .WIDTH(BW)) u_breathe (
        .clk(sys_clk), .rst_n(sys_rst_n), .tick(br_tick), .restart(br_restart),
        .count(br_count), .wrap_c(br_wrap_c)
    );
    char_anim_tick_counter #(.MAX(WALK_DIV), .WIDTH(DW)) u_walk_div (
        .clk(sys_clk), .rst_n(sys_rst_n), .tick(wd_tick), .restart(wd_restart),
        .count(wd_count), .wrap_c(wd_wrap_c)
    );
    char_anim_tick_counter #(.MAX(LAND_HOLD_TICKS), .WIDTH(HW)) u_land_hold (
        .clk(sys_clk), .rst_n(sys_rst_n), .tick(hd_tick), .restart(hd_restart),
        .count(hd_count), .wrap_c(hd_wrap_c)
    );

    // Counter values and the breathe terminal flag are not needed by the selector
    logic unused_ok;
    assign unused_ok = ^{br_wrap_c, wd_count, hd_count};

    // Input stage, pre-landing velocity and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_d     <= 1'b0;
            state_d    <= ST_IDLE;
            vel_x_d    <= '0;
            vel_y_d    <= '0;
            vel_y_prev <= '0;
            frame_id   <= F_IDLE_A;
            mirror     <= 1'b0;
            land_busy  <= 1'b0;
        end else begin
            tick_d    <= character_clk;
            state_d   <= char_state_e'(char_state);
            vel_x_d   <= vel_x;
            vel_y_d   <= vel_y;
            if (tick_d) begin
                vel_y_prev <= vel_y_d;
            end
            frame_id  <= frame_nxt;
            mirror    <= mirror_nxt;
            land_busy <= busy_nxt;
        end
    end

    // Priority frame selector and facing latch
    always_comb begin
        frame_nxt  = frame_id;
        mirror_nxt = mirror;
        busy_nxt   = land_busy;
        br_tick    = 1'b0;
        br_restart = 1'b0;
        wd_tick    = 1'b0;
        wd_restart = 1'b0;
        hd_tick    = 1'b0;
        hd_restart = 1'b0;

        if (tick_d) begin
            if (state_d == ST_CHARGE) begin
                frame_nxt = F_CHARGE;
                busy_nxt  = 1'b0;
            end else if (state_d == ST_JUMP) begin
                busy_nxt = 1'b0;
                if (vy_nz) begin
                    frame_nxt = vy_neg ? F_JUMP_DOWN : F_JUMP_UP;
                end else if (!is_jump) begin
                    frame_nxt = F_JUMP_UP;
                end
            end else if (state_d == ST_COLLISION) begin
                frame_nxt = F_BONK;
            end else if (state_d == ST_FALL) begin
                // A zero pre-landing velocity means no real impact: keep the frame
                if (|vel_y_prev) begin
                    frame_nxt  = (int'(vel_y_prev) < HARD_THRESH) ? F_HARD_LAND : F_SOFT_LAND;
                    busy_nxt   = 1'b1;
                    hd_restart = 1'b1;
                end
            end else if (land_busy) begin
                // Remaining state is IDLE/LEFT/RIGHT/HOLD: freeze until the hold expires
                hd_tick = 1'b1;
                if (hd_wrap_c) begin
                    busy_nxt = 1'b0;
                end
            end else if (state_d == ST_HOLD) begin
                frame_nxt = frame_id;
            end else if ((state_d == ST_LEFT) || (state_d == ST_RIGHT)) begin
                if (!is_walk) begin
                    frame_nxt  = F_WALK_BASE;
                    wd_restart = 1'b1;
                end else begin
                    wd_tick = 1'b1;
                    if (wd_wrap_c) begin
                        frame_nxt = (frame_id == F_WALK_LAST) ? F_WALK_BASE : frame_id + FW'(1);
                    end
                end
            end else if (vy_nz) begin
                // Idle but moving vertically: walked off a ledge
                frame_nxt = vy_neg ? F_JUMP_DOWN : F_JUMP_UP;
            end else if (!is_idle) begin
                frame_nxt  = F_IDLE_A;
                br_restart = 1'b1;
            end else begin
                br_tick   = 1'b1;
                frame_nxt = (br_count < BREATHE_HALF) ? F_IDLE_A : F_IDLE_B;
            end

            if (state_d == ST_LEFT) begin
                mirror_nxt = 1'b1;
            end else if (state_d == ST_RIGHT) begin
                mirror_nxt = 1'b0;
            end else if ((state_d == ST_JUMP) && vx_nz) begin
                mirror_nxt = vx_neg;
            end
        end
    end

endmodule

// File: tb/tb_char_anim_sequencer.sv
// Self-checking bench for char_anim_sequencer: directed scenarios followed by
// randomized stimulus, compared against a tick-level behavioural model.
module tb_char_anim_sequencer;
    import char_anim_pkg::*;

    localparam int unsigned PW           = 17;
    localparam int          REFRESH      = 64;
    localparam int          WALK_FRAMES  = 4;
    localparam int          WALK_DIV     = 8;
    localparam int          LAND_HOLD    = 64;
    localparam int          MAX_VEL_Y    = 10;
    localparam int          HARD_SHIFT   = 2;
    localparam int          HARD_THRESH  = -(MAX_VEL_Y >>> HARD_SHIFT);

    logic                 sys_clk;
    logic                 sys_rst_n;
    logic                 character_clk;
    logic [2:0]           char_state;
    logic signed [PW-1:0] vel_x;
    logic signed [PW-1:0] vel_y;
    logic [3:0]           frame_id;
    logic                 mirror;
    logic                 land_busy;

    int vectors;
    int miscompares;

    // Reference model state
    int m_frame;
    int m_breath;
    int m_div;
    int m_hold;
    int m_prev;
    bit m_mirror;
    bit m_busy;

    int r_st, r_vx, r_vy, cur_st;
    bit r_tk;

    char_anim_sequencer dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .character_clk (character_clk),
        .char_state    (char_state),
        .vel_x         (vel_x),
        .vel_y         (vel_y),
        .frame_id      (frame_id),
        .mirror        (mirror),
        .land_busy     (land_busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
            $error("%s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("frame_id", 32'(frame_id), 32'(m_frame));
        check("mirror", 32'(mirror), 32'(m_mirror));
        check("land_busy", 32'(land_busy), 32'(m_busy));
    endtask

    task automatic model_reset();
        m_frame  = 0;
        m_breath = 0;
        m_div    = 0;
        m_hold   = 0;
        m_prev   = 0;
        m_mirror = 1'b0;
        m_busy   = 1'b0;
    endtask

    // One update tick of the animation rules, in priority order
    task automatic model_tick(input int st, input int vx, input int vy);
        bit walking;
        bit idling;
        bit jumping;
        walking = (m_frame >= 8);
        idling  = (m_frame <= 1);
        jumping = (m_frame == 3) || (m_frame == 4);
        if (st == 3) begin
            m_frame = 2;
            m_busy  = 1'b0;
        end else if (st == 4) begin
            m_busy = 1'b0;
            if (vy > 0) m_frame = 3;
            else if (vy < 0) m_frame = 4;
            else if (!jumping) m_frame = 3;
        end else if (st == 5) begin
            m_frame = 7;
        end else if (st == 6) begin
            if (m_prev != 0) begin
                m_frame = (m_prev < HARD_THRESH) ? 5 : 6;
                m_busy  = 1'b1;
                m_hold  = LAND_HOLD - 1;
            end
        end else if (m_busy) begin
            if (m_hold == 0) m_busy = 1'b0;
            else m_hold--;
        end else if (st == 7) begin
            m_frame = m_frame;
        end else if (st == 1 || st == 2) begin
            if (!walking) begin
                m_frame = 8;
                m_div   = 0;
            end else if (m_div == WALK_DIV - 1) begin
                m_div   = 0;
                m_frame = 8 + ((m_frame - 8 + 1) % WALK_FRAMES);
            end else begin
                m_div++;
            end
        end else if (vy != 0) begin
            m_frame = (vy > 0) ? 3 : 4;
        end else if (!idling) begin
            m_frame  = 0;
            m_breath = 0;
        end else begin
            m_frame  = (m_breath < REFRESH / 2) ? 0 : 1;
            m_breath = (m_breath + 1) % REFRESH;
        end
        if (st == 1) m_mirror = 1'b1;
        else if (st == 2) m_mirror = 1'b0;
        else if (st == 4 && vx < 0) m_mirror = 1'b1;
        else if (st == 4 && vx > 0) m_mirror = 1'b0;
        m_prev = vy;
    endtask

    // Drive one cycle, check outputs (which lag the model by one step), then
    // advance the model if this cycle carried a tick
    task automatic step(input bit tk, input int st, input int vx, input int vy);
        character_clk = tk;
        char_state    = 3'(st);
        vel_x         = PW'(vx);
        vel_y         = PW'(vy);
        @(posedge sys_clk);
        #1;
        check_outputs();
        if (tk) model_tick(st, vx, vy);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        sys_rst_n     = 1'b0;
        character_clk = 1'b0;
        char_state    = 3'd0;
        vel_x         = '0;
        vel_y         = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_outputs();
        sys_rst_n = 1'b1;

        // Breathing from reset
        repeat (70) step(1'b1, ST_IDLE, 0, 0);
        // Walk right then left without restart
        repeat (40) step(1'b1, ST_RIGHT, 0, 0);
        repeat (12) step(1'b1, ST_LEFT, 0, 0);
        // Jump arc and hard landing held while idle
        repeat (3) step(1'b1, ST_JUMP, 3, 5);
        repeat (3) step(1'b1, ST_JUMP, 0, -5);
        step(1'b1, ST_JUMP, 0, -9);
        step(1'b1, ST_FALL, 0, 0);
        repeat (70) step(1'b1, ST_IDLE, 0, 0);
        // Soft landing at threshold, aborted by charge
        step(1'b1, ST_JUMP, -2, -2);
        step(1'b1, ST_FALL, 0, 0);
        repeat (10) step(1'b1, ST_IDLE, 0, 0);
        repeat (3) step(1'b1, ST_CHARGE, 0, 0);
        repeat (3) step(1'b1, ST_IDLE, 0, 0);
        // Collision and frozen hold
        repeat (3) step(1'b1, ST_COLLISION, 0, 0);
        repeat (5) step(1'b1, ST_HOLD, 0, 0);
        // Asynchronous reset in the middle of a landing hold
        step(1'b1, ST_JUMP, 0, -9);
        step(1'b1, ST_FALL, 0, 0);
        repeat (20) step(1'b1, ST_IDLE, 0, 0);
        #3;
        sys_rst_n     = 1'b0;
        character_clk = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        // Inputs without ticks are ignored; a lone tick lands two cycles later
        repeat (3) step(1'b1, ST_RIGHT, 0, 0);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 8)) - 4,
                 int'($urandom_range(0, 8)) - 4);
        end
        step(1'b1, ST_LEFT, 0, 0);
        repeat (3) step(1'b0, ST_CHARGE, 0, 0);

        // Randomized traffic with sticky states so cycles and holds develop
        cur_st = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) cur_st = int'($urandom_range(0, 7));
            r_st = cur_st;
            r_tk = ($urandom_range(0, 9) < 8);
            r_vx = int'($urandom_range(0, 6)) - 3;
            r_vy = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 24)) - 12;
            step(r_tk, r_st, r_vx, r_vy);
        end
        repeat (2) step(1'b0, ST_IDLE, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
